// File: rtl/mc_controller.sv
// Multicycle controller for a small ARM-style datapath: Moore FSM with registered control outputs.
// Optional bus wait-state support is enabled by defining MC_BUS_WAIT_EN (adds the mem_ready input).
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
`ifdef MC_BUS_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_w,
  output logic       ir_w,
  output logic       reg_w,
  output logic       mem_w,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [2:0] alu_control,
  output logic [3:0] state,
  output logic       cond_ex
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  typedef struct packed {
    logic       pc_w;
    logic       ir_w;
    logic       reg_w;
    logic       mem_w;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] result_src;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu_control;
  } ctrl_t;

  state_t      state_q;
  state_t      nxt;
  ctrl_t       ctrl_q;
  logic [3:0]  flags;
  logic        cex_nxt;
  logic        ready;
  logic        fetch_gate;
  logic [3:0]  cmd;

  assign cmd = funct[4:1];

`ifdef MC_BUS_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cy;
      4'b0011: cond_eval = ~cy;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cy & ~z;
      4'b1001: cond_eval = ~cy | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_ctl(input logic [3:0] c);
    case (c)
      4'b0100, 4'b1011: alu_ctl = 3'b000;
      4'b0010, 4'b1010: alu_ctl = 3'b001;
      4'b0000, 4'b1000: alu_ctl = 3'b010;
      4'b1100:          alu_ctl = 3'b011;
      4'b0101:          alu_ctl = 3'b100;
      4'b0001, 4'b1001: alu_ctl = 3'b111;
      default:          alu_ctl = 3'b000;
    endcase
  endfunction

  // add, sub, adc, cmp and cmn are the arithmetic ops that produce meaningful C and V
  function automatic logic sets_cv(input logic [3:0] c);
    sets_cv = (c == 4'b0100) || (c == 4'b0010) || (c == 4'b0101) ||
              (c == 4'b1010) || (c == 4'b1011);
  endfunction

  function automatic ctrl_t decode(input state_t st, input logic cex,
                                   input logic [3:0] dst, input logic [3:0] c);
    ctrl_t o;
    o = '0;
    case (st)
      FETCH: begin
        o.ir_w       = 1'b1;
        o.pc_w       = 1'b1;
        o.alu_src_a  = 1'b1;
        o.alu_src_b  = 2'b10;
        o.result_src = 2'b10;
      end
      DECODE: begin
        o.alu_src_a  = 1'b1;
        o.alu_src_b  = 2'b10;
        o.result_src = 2'b10;
      end
      MEMADR: begin
        o.alu_src_b = 2'b01;
        o.imm_src   = 2'b01;
      end
      MEMRD: o.adr_src = 1'b1;
      MEMWB: begin
        o.result_src = 2'b01;
        o.reg_w      = cex;
        o.pc_w       = cex & (dst == 4'hF);
      end
      MEMWR: begin
        o.adr_src = 1'b1;
        o.reg_src = 2'b10;
        o.mem_w   = cex;
      end
      EXECR: o.alu_control = alu_ctl(c);
      EXECI: begin
        o.alu_src_b   = 2'b01;
        o.alu_control = alu_ctl(c);
      end
      ALUWB: begin
        o.reg_w = cex;
        o.pc_w  = cex & (dst == 4'hF);
      end
      BRANCH: begin
        o.alu_src_b  = 2'b01;
        o.imm_src    = 2'b10;
        o.result_src = 2'b10;
        o.pc_w       = cex;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    nxt = FETCH;
    case (state_q)
      FETCH:  nxt = ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          2'b01:   nxt = MEMADR;
          2'b00:   nxt = funct[5] ? EXECI : EXECR;
          2'b10:   nxt = BRANCH;
          default: nxt = FETCH;
        endcase
      end
      MEMADR: nxt = funct[0] ? MEMRD : MEMWR;
      MEMRD:  nxt = ready ? MEMWB : MEMRD;
      MEMWR:  nxt = ready ? FETCH : MEMWR;
      EXECR, EXECI: nxt = (cmd[3:2] == 2'b10) ? FETCH : ALUWB;
      default: nxt = FETCH;
    endcase
  end

  assign cex_nxt = (state_q == DECODE) ? cond_eval(cond, flags) : cond_ex;

  // Outputs are registered from the next state so they change together with state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      flags   <= 4'b0000;
      cond_ex <= 1'b0;
      ctrl_q  <= decode(FETCH, 1'b0, 4'h0, 4'h0);
    end else begin
      state_q <= nxt;
      cond_ex <= cex_nxt;
      ctrl_q  <= decode(nxt, cex_nxt, rd, cmd);
      if ((state_q == EXECR || state_q == EXECI) && cond_ex && funct[0]) begin
        flags[3:2] <= alu_flags[3:2];
        if (sets_cv(cmd))
          flags[1:0] <= alu_flags[1:0];
      end
    end
  end

  // Write enables drop as soon as reset rises; fetch strobes also wait for the bus
  assign fetch_gate  = (state_q != FETCH) | ready;
  assign pc_w        = ctrl_q.pc_w & ~reset & fetch_gate;
  assign ir_w        = ctrl_q.ir_w & ~reset & fetch_gate;
  assign reg_w       = ctrl_q.reg_w & ~reset;
  assign mem_w       = ctrl_q.mem_w & ~reset;
  assign adr_src     = ctrl_q.adr_src;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign result_src  = ctrl_q.result_src;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign imm_src     = ctrl_q.imm_src;
  assign reg_src     = ctrl_q.reg_src;
  assign alu_control = ctrl_q.alu_control;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction scenarios plus random instructions checked
// against a behavioural model of the instruction flow, condition codes and flags.
module tb_mc_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd, cond, alu_flags;
`ifdef MC_BUS_WAIT_EN
  logic        mem_ready;
`endif
  logic        pc_w, ir_w, reg_w, mem_w, adr_src, alu_src_a;
  logic [1:0]  result_src, alu_src_b, imm_src, reg_src;
  logic [2:0]  alu_control;
  logic [3:0]  state;
  logic        cond_ex;
  logic [16:0] ctrl_vec;
  logic [3:0]  mflags;
  int          checks = 0;
  int          errors = 0;

  localparam logic [16:0] RESET_CTRL = 17'b0_0_0_0_0_1_10_10_00_00_000;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond(cond),
    .alu_flags(alu_flags),
`ifdef MC_BUS_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_w(pc_w), .ir_w(ir_w), .reg_w(reg_w), .mem_w(mem_w), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .result_src(result_src), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .reg_src(reg_src), .alu_control(alu_control),
    .state(state), .cond_ex(cond_ex)
  );

  assign ctrl_vec = {pc_w, ir_w, reg_w, mem_w, adr_src, alu_src_a,
                     result_src, alu_src_b, imm_src, reg_src, alu_control};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Condition codes come in complementary pairs: odd codes negate the even code before them
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v, base;
    {n, z, cy, v} = fl;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  function automatic logic [2:0] alu_model(input logic [3:0] c);
    case (c)
      4'b0010, 4'b1010: return 3'd1;
      4'b0000, 4'b1000: return 3'd2;
      4'b1100:          return 3'd3;
      4'b0101:          return 3'd4;
      4'b0001, 4'b1001: return 3'd7;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic logic [16:0] exp_out(input int st, input logic cex,
                                          input logic [3:0] r, input logic [5:0] f);
    logic pw, iw, rw, mw, adr, srca;
    logic [1:0] res, srcb, imm, rsrc;
    logic [2:0] ac;
    {pw, iw, rw, mw, adr, srca} = 6'b0;
    res = 2'd0; srcb = 2'd0; imm = 2'd0; rsrc = 2'd0; ac = 3'd0;
    case (st)
      0: begin iw = 1'b1; pw = 1'b1; srca = 1'b1; srcb = 2'd2; res = 2'd2; end
      1: begin srca = 1'b1; srcb = 2'd2; res = 2'd2; end
      2: begin srcb = 2'd1; imm = 2'd1; end
      3: adr = 1'b1;
      4: begin res = 2'd1; rw = cex; pw = cex && (r == 4'hF); end
      5: begin adr = 1'b1; rsrc = 2'd2; mw = cex; end
      6: ac = alu_model(f[4:1]);
      7: begin srcb = 2'd1; ac = alu_model(f[4:1]); end
      8: begin rw = cex; pw = cex && (r == 4'hF); end
      9: begin srcb = 2'd1; imm = 2'd2; res = 2'd2; pw = cex; end
      default: ;
    endcase
    return {pw, iw, rw, mw, adr, srca, res, srcb, imm, rsrc, ac};
  endfunction

  // Called at a sample point while the DUT sits in FETCH; walks the whole instruction
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input logic [3:0] c, input logic [3:0] af);
    int seq[$];
    logic cex;
    logic [3:0] cm;
    op = o; funct = f; rd = r; cond = c; alu_flags = af;
    cm = f[4:1];
    cex = cond_model(c, mflags);
    seq = '{0, 1};
    case (o)
      2'b01: begin
        seq.push_back(2);
        if (f[0]) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end
      2'b00: begin
        seq.push_back(f[5] ? 7 : 6);
        if (cm[3:2] != 2'b10) seq.push_back(8);
      end
      2'b10: seq.push_back(9);
      default: ;
    endcase
    foreach (seq[i]) begin
      chk("state", 32'(state), 32'(seq[i]));
      chk("ctrl", 32'(ctrl_vec), 32'(exp_out(seq[i], cex, r, f)));
      if (i >= 2) chk("cond_ex", 32'(cond_ex), 32'(cex));
      if ((seq[i] == 6 || seq[i] == 7) && cex && f[0]) begin
        mflags[3:2] = af[3:2];
        if (cm inside {4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b1011})
          mflags[1:0] = af[1:0];
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset = 1'b1; op = 2'b11; funct = 6'd0; rd = 4'd0; cond = 4'b1110; alu_flags = 4'd0;
`ifdef MC_BUS_WAIT_EN
    mem_ready = 1'b1;
`endif
    mflags = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctrl", 32'(ctrl_vec), 32'(RESET_CTRL));
    chk("reset_cond_ex", 32'(cond_ex), 32'd0);
    reset = 1'b0;
    #1;
    chk("release_ctrl", 32'(ctrl_vec), 32'(exp_out(0, 1'b0, 4'd0, 6'd0)));

    // LDR r3, cond AL
    run_instr(2'b01, 6'b011001, 4'd3, 4'b1110, 4'd0);
    // SUBS setting Z, then BEQ taken
    run_instr(2'b00, 6'b000101, 4'd2, 4'b1110, 4'b0100);
    run_instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'd0);
    // SUBS clearing Z, then BEQ not taken
    run_instr(2'b00, 6'b000101, 4'd2, 4'b1110, 4'b0000);
    run_instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'd0);
    // CMP immediate
    run_instr(2'b00, 6'b110101, 4'd0, 4'b1110, 4'b1011);
    // Z set, then STR with NE must not write
    run_instr(2'b00, 6'b000101, 4'd2, 4'b1110, 4'b0100);
    run_instr(2'b01, 6'b011000, 4'd5, 4'b0001, 4'd0);
    // Writes to PC through ALUWB and MEMWB
    run_instr(2'b00, 6'b001000, 4'hF, 4'b1110, 4'd0);
    run_instr(2'b01, 6'b011001, 4'hF, 4'b1110, 4'd0);
    run_instr(2'b11, 6'b000000, 4'd0, 4'b1110, 4'd0);
    // Set Z, C and V before a reset mid-store
    run_instr(2'b00, 6'b001001, 4'd1, 4'b1110, 4'b0111);

    op = 2'b01; funct = 6'b000000; rd = 4'd1; cond = 4'b1110;
    repeat (3) begin @(posedge clk); #1; end
    chk("memwr_state", 32'(state), 32'd5);
    chk("memwr_mem_w", 32'(mem_w), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_ctrl", 32'(ctrl_vec), 32'(RESET_CTRL));
    chk("midrst_cond_ex", 32'(cond_ex), 32'd0);
    mflags = 4'd0;
    #2 reset = 1'b0;
    #1;
    // Flags were cleared: EQ and CS branches must not be taken
    run_instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'd0);
    run_instr(2'b10, 6'b100000, 4'd0, 4'b0010, 4'd0);

`ifdef MC_BUS_WAIT_EN
    op = 2'b11;
    mem_ready = 1'b0;
    #1;
    repeat (3) begin
      chk("wait_state", 32'(state), 32'd0);
      chk("wait_ir_w", 32'(ir_w), 32'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #1;
    chk("ready_ir_w", 32'(ir_w), 32'd1);
    chk("ready_pc_w", 32'(pc_w), 32'd1);
    @(posedge clk); #1;
    chk("ready_decode", 32'(state), 32'd1);
    @(posedge clk); #1;
    chk("ready_refetch", 32'(state), 32'd0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic [3:0] rr;
      rr = 4'($urandom_range(0, 15));
      if (k % 4 == 0) rr = 4'hF;
      run_instr(2'($urandom), 6'($urandom), rr, 4'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
